stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
Command front-end that drives the LIFO stack storage block. It accepts stack-machine commands over a valid/ready handshake and owns the stack pointer. It sequences the storage block's push/pop/data_in/pointer signals to execute PUSH, POP, DUP and two-operand ALU ops, and returns popped or computed values on a result strobe. Over/underflow is detected here, before any storage access.

Parameters:
WIDTH, 8, data word width in bits; must match the storage block.
DEPTH, 2, number of stack entries; also the pointer width in bits, as on the storage block; DEPTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE
cmd_op  input  3  0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 AND, 6 XOR, 7 DUP
cmd_data  input  WIDTH  PUSH operand; ignored for other ops
res_valid  output  1  one-cycle result strobe; no backpressure
res_data  output  WIDTH  popped value or ALU result
err_valid  output  1  one-cycle strobe: command rejected
err_ovf  output  1  sticky overflow flag
err_unf  output  1  sticky underflow flag
stk_push  output  1  to storage push
stk_pop  output  1  to storage pop
stk_data_in  output  WIDTH  to storage data_in
stk_pointer  output  DEPTH  to storage pointer; equals occupancy count 0..DEPTH
stk_data_out  input  WIDTH  from storage data_out

Behaviour:
- Reset: state IDLE, stk_pointer 0, and every output 0 except cmd_ready (1). Reset during any operation aborts it, with no further storage access.
- Storage timing contract: with stk_push=1 and pointer p, lifo[p] is written at the edge; with stk_pop=1, stk_data_out = lifo[p-1] the following cycle. The sequencer updates stk_pointer (+1/-1) on the same edge as each push/pop. stk_push and stk_pop are never both high.
- All outputs are registered. Accept is cmd_valid && cmd_ready at cycle T.
- Check at accept, with count = stk_pointer:
  - Overflow: PUSH or DUP with count == DEPTH.
  - Underflow: POP or DUP with count == 0; ALU ops with count < 2.
- Rejected command: consumed, no storage access, stay IDLE. err_valid=1 at T+1; err_ovf or err_unf set, and held until rst.
- NOP: consumed, no action.
- States: IDLE, POP_A, CAPT_A, POP_B, CAPT_B, PUSH_R, PUSH_D, DONE.
- PUSH: T+1 PUSH_R, with stk_push=1 and stk_data_in=cmd_data latched at T. Pointer +1. IDLE at T+2. No res_valid.
- POP: T+1 POP_A (stk_pop=1, pointer -1). T+2 CAPT_A latches a=stk_data_out. T+3 res_valid=1, res_data=a, state IDLE.
- ALU: POP_A, CAPT_A (a = top), POP_B, CAPT_B (b = next) over T+1..T+4.
  - T+5 PUSH_R pushes r = b op a: SUB = b - a; ADD/SUB modulo 2^WIDTH, carry/borrow discarded.
  - T+6 res_valid=1, res_data=r, state IDLE. Net pointer -1.
- DUP: POP_A, CAPT_A, then PUSH_R (a) and PUSH_D (a) on consecutive cycles; net pointer +1. T+5 res_valid=1, res_data=a, state IDLE.
- DONE drives res_valid for exactly one cycle. cmd_ready=0 in every state except IDLE.

Optional Feature:
STACK_SEQ_OPCNT_EN: adds output op_count [15:0]. It resets to 0, increments once per successfully completed non-NOP command, and saturates at 16'hFFFF; rejected commands are not counted. Without the macro the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
DEPTH=4, WIDTH=8. PUSH 8'h05 then PUSH 8'h03, then ADD -> res_data 8'h08 at T+6, stk_pointer 1 at end.
PUSH 8'h02, PUSH 8'h07, SUB -> res_data 8'hFB (2-7 wrap); POP -> res_data 8'hFB, stk_pointer 0.
POP on empty -> err_valid pulse at T+1, err_unf=1 sticky, stk_pop never asserted, stk_pointer stays 0.
PUSH 8'hA0..8'hA3 (fills 4), then PUSH 8'hFF -> err_ovf=1, no stk_push. DUP -> also rejected. POP -> 8'hA3.
PUSH 8'h3C, DUP, XOR -> DUP res 8'h3C, XOR res 8'h00, final stk_pointer 1; cmd_ready low throughout each op.
Assert rst during the POP_B state of ADD -> all outputs 0, stk_pointer 0, cmd_ready 1 after release, and a following PUSH works normally.

Source files
------------

// File: rtl/stack_sequencer.sv
// stack_sequencer: command front-end for the LIFO stack storage block.
// Accepts PUSH/POP/DUP/ALU commands over valid/ready, owns the stack pointer,
// sequences storage push/pop cycles and returns results on a one-cycle strobe.
// Over/underflow is detected at accept time, before any storage access.
// Optional feature: define STACK_SEQ_OPCNT_EN to add the op_count output
// (saturating count of successfully completed non-NOP commands).

module stack_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             err_valid,
    output logic             err_ovf,
    output logic             err_unf,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_data_in,
    output logic [DEPTH-1:0] stk_pointer,
    input  logic [WIDTH-1:0] stk_data_out
`ifdef STACK_SEQ_OPCNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_AND  = 3'd5,
        OP_XOR  = 3'd6,
        OP_DUP  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        POP_A,
        CAPT_A,
        POP_B,
        CAPT_B,
        PUSH_R,
        PUSH_D,
        DONE
    } state_t;

    localparam logic [DEPTH-1:0] FULL_COUNT = DEPTH'(DEPTH);
    localparam logic [DEPTH-1:0] ONE        = DEPTH'(1);
    localparam logic [DEPTH-1:0] TWO        = DEPTH'(2);

    state_t           state;
    state_t           state_next;
    op_t              op_q;
    op_t              op_next;
    op_t              op_in;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_next;

    logic             accept;
    logic             stack_full;
    logic             stack_empty;
    logic             below_two;
    logic             reject_ovf;
    logic             reject_unf;

    logic             cmd_ready_next;
    logic             res_valid_next;
    logic [WIDTH-1:0] res_data_next;
    logic             err_valid_next;
    logic             err_ovf_next;
    logic             err_unf_next;
    logic             stk_push_next;
    logic             stk_pop_next;
    logic [WIDTH-1:0] stk_data_in_next;
    logic [DEPTH-1:0] stk_pointer_next;

    // Two-operand result: b is the element below the top, a is the top.
    function automatic logic [WIDTH-1:0] alu_result(
        input op_t              op,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] a
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = b + a;
            OP_SUB:  r = b - a;
            OP_AND:  r = b & a;
            OP_XOR:  r = b ^ a;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Classify the offered command against the current occupancy
    always_comb begin
        op_in       = op_t'(cmd_op);
        accept      = cmd_valid && cmd_ready;
        stack_full  = (stk_pointer == FULL_COUNT);
        stack_empty = (stk_pointer == '0);
        below_two   = (stk_pointer < TWO);
        reject_ovf  = 1'b0;
        reject_unf  = 1'b0;
        case (op_in)
            OP_PUSH: reject_ovf = stack_full;
            OP_POP:  reject_unf = stack_empty;
            OP_DUP: begin
                reject_ovf = stack_full;
                reject_unf = stack_empty;
            end
            OP_ADD, OP_SUB, OP_AND, OP_XOR: reject_unf = below_two;
            default: begin
                reject_ovf = 1'b0;
                reject_unf = 1'b0;
            end
        endcase
    end

    // Next-state sequencing and operand/result capture
    always_comb begin
        state_next       = state;
        op_next          = op_q;
        a_next           = a_q;
        res_data_next    = res_data;
        stk_data_in_next = stk_data_in;
        err_valid_next   = 1'b0;
        err_ovf_next     = err_ovf;
        err_unf_next     = err_unf;

        case (state)
            IDLE: begin
                if (accept) begin
                    op_next = op_in;
                    if (reject_ovf) begin
                        err_valid_next = 1'b1;
                        err_ovf_next   = 1'b1;
                    end else if (reject_unf) begin
                        err_valid_next = 1'b1;
                        err_unf_next   = 1'b1;
                    end else begin
                        case (op_in)
                            OP_NOP: state_next = IDLE;
                            OP_PUSH: begin
                                state_next       = PUSH_R;
                                stk_data_in_next = cmd_data;
                            end
                            default: state_next = POP_A;
                        endcase
                    end
                end
            end
            POP_A: state_next = CAPT_A;
            CAPT_A: begin
                a_next = stk_data_out;
                case (op_q)
                    OP_POP: begin
                        res_data_next = stk_data_out;
                        state_next    = DONE;
                    end
                    OP_DUP: begin
                        stk_data_in_next = stk_data_out;
                        state_next       = PUSH_R;
                    end
                    default: state_next = POP_B;
                endcase
            end
            POP_B: state_next = CAPT_B;
            CAPT_B: begin
                stk_data_in_next = alu_result(op_q, stk_data_out, a_q);
                state_next       = PUSH_R;
            end
            PUSH_R: begin
                case (op_q)
                    OP_PUSH: state_next = IDLE;
                    OP_DUP:  state_next = PUSH_D;
                    default: begin
                        res_data_next = stk_data_in;
                        state_next    = DONE;
                    end
                endcase
            end
            PUSH_D: begin
                res_data_next = stk_data_in;
                state_next    = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are decoded from the state being entered
    always_comb begin
        cmd_ready_next = (state_next == IDLE);
        res_valid_next = (state_next == DONE);
        stk_push_next  = (state_next == PUSH_R) || (state_next == PUSH_D);
        stk_pop_next   = (state_next == POP_A) || (state_next == POP_B);
    end

    // Pointer follows the storage access issued in the current cycle
    always_comb begin
        stk_pointer_next = stk_pointer;
        if (stk_push) begin
            stk_pointer_next = stk_pointer + ONE;
        end else if (stk_pop) begin
            stk_pointer_next = stk_pointer - ONE;
        end
    end

    // State, operand and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_NOP;
            a_q         <= '0;
            cmd_ready   <= 1'b1;
            res_valid   <= 1'b0;
            res_data    <= '0;
            err_valid   <= 1'b0;
            err_ovf     <= 1'b0;
            err_unf     <= 1'b0;
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            stk_data_in <= '0;
            stk_pointer <= '0;
        end else begin
            state       <= state_next;
            op_q        <= op_next;
            a_q         <= a_next;
            cmd_ready   <= cmd_ready_next;
            res_valid   <= res_valid_next;
            res_data    <= res_data_next;
            err_valid   <= err_valid_next;
            err_ovf     <= err_ovf_next;
            err_unf     <= err_unf_next;
            stk_push    <= stk_push_next;
            stk_pop     <= stk_pop_next;
            stk_data_in <= stk_data_in_next;
            stk_pointer <= stk_pointer_next;
        end
    end

`ifdef STACK_SEQ_OPCNT_EN
    logic op_done;

    // A command completes when the sequencer falls back to IDLE from a busy state
    always_comb begin
        op_done = (state != IDLE) && (state_next == IDLE);
    end

    // Count completed commands, holding at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (op_done && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Testbench for stack_sequencer (DEPTH=4, WIDTH=8) with a behavioural LIFO
// storage block and a queue-based reference model of the command set.

module tb_stack_sequencer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_ready;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         err_valid;
    logic         err_ovf;
    logic         err_unf;
    logic         stk_push;
    logic         stk_pop;
    logic [W-1:0] stk_data_in;
    logic [D-1:0] stk_pointer;
    logic [W-1:0] stk_data_out = '0;

    logic [W-1:0] lifo [0:D-1];

    int errors = 0;
    int checks = 0;

    // Observation window of one command (cycles T+1..T+8)
    logic [8:0]   obs_res_v;
    logic [8:0]   obs_err_v;
    logic [8:0]   obs_rdy;
    logic [W-1:0] obs_res_d [1:8];
    int           obs_push;
    int           obs_pop;
    logic [D-1:0] obs_ptr;

    // Reference model state
    logic [W-1:0] ref_stk [$];
    logic         exp_ovf;
    logic         exp_unf;
    int           exp_kind;
    int           exp_lat;
    int           exp_busy;
    logic [W-1:0] exp_val;
    int           exp_push;
    int           exp_pop;

    stack_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .err_valid    (err_valid),
        .err_ovf      (err_ovf),
        .err_unf      (err_unf),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_pointer  (stk_pointer),
        .stk_data_out (stk_data_out)
    );

    always #5 clk = ~clk;

    // Storage block: write lifo[p] on push, read lifo[p-1] on pop
    always @(posedge clk) begin
        if (stk_push && stk_pointer < 4'd4)
            lifo[stk_pointer[1:0]] <= stk_data_in;
        if (stk_pop && stk_pointer != 4'd0)
            stk_data_out <= lifo[2'(stk_pointer - 4'd1)];
    end

    task automatic model_cmd(input logic [2:0] op, input logic [W-1:0] d);
        int n;
        logic [W-1:0] a;
        logic [W-1:0] b;
        n = ref_stk.size();
        exp_kind = 0; exp_lat = 0; exp_busy = 0; exp_val = '0; exp_push = 0; exp_pop = 0;
        case (op)
            3'd0: ;
            3'd1: begin
                if (n == D) exp_kind = 1;
                else begin ref_stk.push_back(d); exp_push = 1; exp_busy = 1; end
            end
            3'd2: begin
                if (n == 0) exp_kind = 2;
                else begin exp_val = ref_stk.pop_back(); exp_lat = 3; exp_pop = 1; end
            end
            3'd7: begin
                if (n == D) exp_kind = 1;
                else if (n == 0) exp_kind = 2;
                else begin
                    exp_val = ref_stk[n-1];
                    ref_stk.push_back(exp_val);
                    exp_lat = 5; exp_push = 2; exp_pop = 1;
                end
            end
            default: begin
                if (n < 2) exp_kind = 2;
                else begin
                    a = ref_stk.pop_back();
                    b = ref_stk.pop_back();
                    case (op)
                        3'd3: exp_val = W'((int'(b) + int'(a)) % 256);
                        3'd4: exp_val = W'((int'(b) - int'(a) + 256) % 256);
                        3'd5: exp_val = b & a;
                        default: exp_val = b ^ a;
                    endcase
                    ref_stk.push_back(exp_val);
                    exp_lat = 6; exp_push = 1; exp_pop = 2;
                end
            end
        endcase
        if (exp_lat != 0) exp_busy = exp_lat - 1;
        if (exp_kind == 1) exp_ovf = 1'b1;
        if (exp_kind == 2) exp_unf = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_stk.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        @(negedge clk);
    endtask

    // Drive one command, update the model, record 8 cycles of DUT behaviour
    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d);
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
        end
        model_cmd(op, d);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom);
        cmd_data = W'($urandom);
        obs_res_v = '0; obs_err_v = '0; obs_rdy = '0;
        obs_push = 0; obs_pop = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            obs_res_v[k] = res_valid;
            obs_err_v[k] = err_valid;
            obs_rdy[k]   = cmd_ready;
            obs_res_d[k] = res_data;
            if (stk_push === 1'b1) obs_push++;
            if (stk_pop === 1'b1) obs_pop++;
        end
        obs_ptr = stk_pointer;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cmd_ready, res_valid, err_valid, err_ovf, err_unf, stk_push, stk_pop} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 1000000",
                     {cmd_ready, res_valid, err_valid, err_ovf, err_unf, stk_push, stk_pop});
        end
        checks++;
        if (stk_pointer !== 4'd0) begin
            errors++; $display("FAIL reset_ptr: got %0d required 0", stk_pointer);
        end
        checks++;
        if (res_data !== 8'h00 || stk_data_in !== 8'h00) begin
            errors++; $display("FAIL reset_data: res_data=%h data_in=%h required 00", res_data, stk_data_in);
        end
    endtask

    task automatic test_add();
        do_reset();
        run_cmd(3'd1, 8'h05);
        checks++;
        if (obs_push != 1 || obs_res_v !== 9'd0 || obs_ptr !== 4'd1) begin
            errors++;
            $display("FAIL push_basic: push=%0d res_v=%b ptr=%0d required 1/0/1", obs_push, obs_res_v, obs_ptr);
        end
        run_cmd(3'd1, 8'h03);
        run_cmd(3'd3, 8'h00);
        checks++;
        if (obs_res_v !== 9'b001000000) begin
            errors++; $display("FAIL add_timing: res_v=%b required 001000000", obs_res_v);
        end
        checks++;
        if (obs_res_d[6] !== 8'h08) begin
            errors++; $display("FAIL add_res: got %h required 08", obs_res_d[6]);
        end
        checks++;
        if (obs_ptr !== 4'd1 || obs_push != 1 || obs_pop != 2) begin
            errors++;
            $display("FAIL add_ptr: ptr=%0d push=%0d pop=%0d required 1/1/2", obs_ptr, obs_push, obs_pop);
        end
    endtask

    task automatic test_sub_pop();
        do_reset();
        run_cmd(3'd1, 8'h02);
        run_cmd(3'd1, 8'h07);
        run_cmd(3'd4, 8'h00);
        checks++;
        if (obs_res_v[6] !== 1'b1 || obs_res_d[6] !== 8'hFB) begin
            errors++; $display("FAIL sub_res: valid=%b data=%h required 1/FB", obs_res_v[6], obs_res_d[6]);
        end
        run_cmd(3'd2, 8'h00);
        checks++;
        if (obs_res_v !== 9'b000001000 || obs_res_d[3] !== 8'hFB) begin
            errors++; $display("FAIL pop_res: res_v=%b data=%h required 000001000/FB", obs_res_v, obs_res_d[3]);
        end
        checks++;
        if (obs_ptr !== 4'd0) begin
            errors++; $display("FAIL pop_ptr: got %0d required 0", obs_ptr);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        run_cmd(3'd2, 8'h00);
        checks++;
        if (obs_err_v !== 9'b000000010) begin
            errors++; $display("FAIL unf_strobe: err_v=%b required 000000010", obs_err_v);
        end
        checks++;
        if (obs_pop != 0 || obs_ptr !== 4'd0 || obs_res_v !== 9'd0) begin
            errors++;
            $display("FAIL unf_noaccess: pop=%0d ptr=%0d res_v=%b required 0/0/0", obs_pop, obs_ptr, obs_res_v);
        end
        run_cmd(3'd0, 8'h00);
        checks++;
        if ({err_unf, err_ovf} !== 2'b10 || obs_err_v !== 9'd0) begin
            errors++; $display("FAIL unf_sticky: unf/ovf=%b err_v=%b required 10/0", {err_unf, err_ovf}, obs_err_v);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) run_cmd(3'd1, 8'hA0 + 8'(i));
        run_cmd(3'd1, 8'hFF);
        checks++;
        if (obs_err_v !== 9'b000000010 || err_ovf !== 1'b1 || err_unf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_push: err_v=%b ovf=%b unf=%b required 000000010/1/0", obs_err_v, err_ovf, err_unf);
        end
        checks++;
        if (obs_push != 0 || obs_ptr !== 4'd4) begin
            errors++; $display("FAIL ovf_noaccess: push=%0d ptr=%0d required 0/4", obs_push, obs_ptr);
        end
        run_cmd(3'd7, 8'h00);
        checks++;
        if (obs_err_v !== 9'b000000010 || obs_push != 0 || obs_pop != 0) begin
            errors++;
            $display("FAIL ovf_dup: err_v=%b push=%0d pop=%0d required 000000010/0/0", obs_err_v, obs_push, obs_pop);
        end
        run_cmd(3'd2, 8'h00);
        checks++;
        if (obs_res_d[3] !== 8'hA3 || obs_ptr !== 4'd3) begin
            errors++; $display("FAIL ovf_pop: data=%h ptr=%0d required A3/3", obs_res_d[3], obs_ptr);
        end
    endtask

    task automatic test_dup_xor();
        do_reset();
        run_cmd(3'd1, 8'h3C);
        checks++;
        if (obs_rdy !== 9'b111111100) begin
            errors++; $display("FAIL push_ready: rdy=%b required 111111100", obs_rdy);
        end
        run_cmd(3'd7, 8'h00);
        checks++;
        if (obs_res_v !== 9'b000100000 || obs_res_d[5] !== 8'h3C) begin
            errors++; $display("FAIL dup_res: res_v=%b data=%h required 000100000/3C", obs_res_v, obs_res_d[5]);
        end
        checks++;
        if (obs_rdy[4:1] !== 4'b0000 || obs_rdy[8:6] !== 3'b111 || obs_ptr !== 4'd2) begin
            errors++; $display("FAIL dup_ready: rdy=%b ptr=%0d required 111x0000x/2", obs_rdy, obs_ptr);
        end
        run_cmd(3'd6, 8'h00);
        checks++;
        if (obs_res_v[6] !== 1'b1 || obs_res_d[6] !== 8'h00 || obs_ptr !== 4'd1) begin
            errors++;
            $display("FAIL xor_res: valid=%b data=%h ptr=%0d required 1/00/1", obs_res_v[6], obs_res_d[6], obs_ptr);
        end
        checks++;
        if (obs_rdy[5:1] !== 5'b00000 || obs_rdy[8:7] !== 2'b11) begin
            errors++; $display("FAIL xor_ready: rdy=%b required 11x00000x", obs_rdy);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [8:0] exp_rdy;
        logic [8:0] mask;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) op = 3'd1;
            run_cmd(op, W'($urandom));
            checks++;
            if (obs_err_v !== ((exp_kind != 0) ? 9'b000000010 : 9'd0)) begin
                errors++; $display("FAIL rnd_err[%0d] op=%0d: err_v=%b kind=%0d", i, op, obs_err_v, exp_kind);
            end
            checks++;
            if ({err_ovf, err_unf} !== {exp_ovf, exp_unf}) begin
                errors++; $display("FAIL rnd_flags[%0d]: got %b required %b", i, {err_ovf, err_unf}, {exp_ovf, exp_unf});
            end
            checks++;
            if (obs_res_v !== ((exp_lat != 0) ? (9'd1 << exp_lat) : 9'd0)) begin
                errors++; $display("FAIL rnd_resv[%0d] op=%0d: got %b latency %0d", i, op, obs_res_v, exp_lat);
            end
            if (exp_lat != 0) begin
                checks++;
                if (obs_res_d[exp_lat] !== exp_val) begin
                    errors++; $display("FAIL rnd_data[%0d] op=%0d: got %h required %h", i, op, obs_res_d[exp_lat], exp_val);
                end
            end
            checks++;
            if (obs_push != exp_push || obs_pop != exp_pop) begin
                errors++;
                $display("FAIL rnd_access[%0d] op=%0d: push=%0d pop=%0d required %0d/%0d", i, op, obs_push, obs_pop, exp_push, exp_pop);
            end
            exp_rdy = '0;
            mask = '0;
            for (int k = 1; k <= 8; k++) begin
                if (k != exp_lat) begin
                    mask[k] = 1'b1;
                    exp_rdy[k] = (k > exp_busy);
                end
            end
            checks++;
            if ((obs_rdy & mask) !== exp_rdy) begin
                errors++; $display("FAIL rnd_ready[%0d] op=%0d: got %b required %b", i, op, obs_rdy & mask, exp_rdy);
            end
            checks++;
            if (int'(obs_ptr) != ref_stk.size()) begin
                errors++; $display("FAIL rnd_ptr[%0d]: got %0d required %0d", i, obs_ptr, ref_stk.size());
            end
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        run_cmd(3'd1, 8'h11);
        run_cmd(3'd1, 8'h22);
        cmd_valid = 1'b1;
        cmd_op = 3'd3;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (stk_pop !== 1'b1 || stk_pointer !== 4'd1) begin
            errors++; $display("FAIL mid_popb: pop=%b ptr=%0d required 1/1", stk_pop, stk_pointer);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, res_valid, err_valid, err_ovf, err_unf, stk_push, stk_pop} !== 7'b1000000
            || stk_pointer !== 4'd0 || res_data !== 8'h00 || stk_data_in !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: flags=%b ptr=%0d res=%h din=%h required 1000000/0/00/00",
                     {cmd_ready, res_valid, err_valid, err_ovf, err_unf, stk_push, stk_pop},
                     stk_pointer, res_data, stk_data_in);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_stk.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || stk_pointer !== 4'd0 || stk_push !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: ready=%b ptr=%0d push=%b res_v=%b required 1/0/0/0",
                     cmd_ready, stk_pointer, stk_push, res_valid);
        end
        run_cmd(3'd1, 8'h5A);
        checks++;
        if (obs_push != 1 || obs_ptr !== 4'd1) begin
            errors++; $display("FAIL mid_push: push=%0d ptr=%0d required 1/1", obs_push, obs_ptr);
        end
        run_cmd(3'd2, 8'h00);
        checks++;
        if (obs_res_v[3] !== 1'b1 || obs_res_d[3] !== 8'h5A || obs_ptr !== 4'd0) begin
            errors++;
            $display("FAIL mid_pop: valid=%b data=%h ptr=%0d required 1/5A/0", obs_res_v[3], obs_res_d[3], obs_ptr);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_pop();
        test_underflow();
        test_overflow();
        test_dup_xor();
        test_random();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
